uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side counterpart to the UART transmit FIFO path. Deserialises an 8N1 UART line into bytes and stores them in an internal first-word-fall-through FIFO that the PC side drains with a read strobe. It is instantiated in the UART top next to the TX FIFO and transmitter, with `rx` fed either from the pin or from the `tx` loopback. It replaces the bare receiver-to-`pc_out_r` connection, so back-to-back frames are buffered instead of overwritten.

## Interface
- `BAUD_DIV`, 100: clock cycles per bit; must be ≥ 4.
- `DEPTH`, 16: FIFO entries; must be a power of two.
- `AW`, 4: log2(`DEPTH`).

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `rd_en`  in  1  pops the head byte; ignored when `fifo_empty`.
- `clr_err`  in  1  clears the sticky `overrun` flag.
- `data_out`  out  8  head-of-FIFO byte; valid while `!fifo_empty`.
- `rx_done`  out  1  one-cycle pulse per byte written to the FIFO.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  AW+1  number of stored entries.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  sticky; set when a valid byte arrives while the FIFO is full.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised signal `rxs`.
- **FSM states:** IDLE, START, DATA, STOP. It uses a baud counter of width clog2(`BAUD_DIV`), a bit index 0–7 and a shift register.
- **IDLE:** when `rxs`==0, go to START and clear the counter.
- **START:** when counter == `BAUD_DIV`/2−1, sample `rxs`.
  - If 0: go to DATA and clear the counter and bit index.
  - If 1: false start; return to IDLE with no outputs.
- **DATA:** every `BAUD_DIV` cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
- **STOP:** after `BAUD_DIV` cycles, sample `rxs`, then go to IDLE in the same edge. This allows a new start edge half a bit later.
  - `rxs`==1 and FIFO not full (or full with `rd_en` on that edge): write the byte and pulse `rx_done`.
  - `rxs`==1 and FIFO full with no `rd_en`: drop the byte, set `overrun`, no `rx_done`.
  - `rxs`==0: drop the byte and pulse `frame_err`. This applies even if the byte is 0x00 (break).
- **FIFO:** `DEPTH`×8 memory with `AW`-bit read/write pointers that wrap modulo `DEPTH`. `data_out` = mem[rd_ptr], i.e. show-ahead.
  - `count` increments on write, decrements on pop, and is unchanged on simultaneous write and pop.
  - Simultaneous write and `rd_en` when empty: the write occurs and the pop is ignored.
  - Simultaneous write and `rd_en` when full: both occur; `count` stays `DEPTH`.
- **`clr_err`:** clears `overrun`. If a set and a clear happen in the same cycle, the set wins.
- **Reset (asynchronous, any state):** FSM → IDLE, counters → 0, pointers → 0, `count`=0, `fifo_empty`=1, `fifo_full`=0, `rx_done`=0, `frame_err`=0, `overrun`=0, `data_out`=0 (memory contents are not reset). A frame in flight is abandoned. After reset the FSM waits in IDLE for a new falling edge, so a line held low after reset is treated as a start.

## Timing
- Let edge E be the first edge at which the FSM sees `rxs`==0 in IDLE. This is 2–3 cycles after the pin falls.
- Sample edges:
  - Start sample: E + `BAUD_DIV`/2.
  - Data bit i (0–7): E + `BAUD_DIV`/2 + (i+1)·`BAUD_DIV`.
  - Stop sample: E + `BAUD_DIV`/2 + 9·`BAUD_DIV`.
- `rx_done`, `frame_err` and the FIFO write all become visible in the cycle after the stop-sample edge, for exactly one cycle.
- If the FIFO was empty, `data_out` shows the new byte and `fifo_empty` deasserts in that same cycle.
- Pop: after the `rd_en` edge, `data_out` shows the next entry in the following cycle and `count` decrements.
- Back-to-back frames with no idle gap are received without loss. Up to ±4% baud mismatch is tolerated.

## Test plan
All scenarios use `BAUD_DIV`=16 and `DEPTH`=4.
1. **Reset state:** assert `rst_n`=0 mid-frame → all outputs take their reset values immediately. After release, a frame 0xA5 is received correctly: `data_out`=0xA5, `count`=1.
2. **Back-to-back frames:** 0x55, 0x00, 0xFF with no gaps → three `rx_done` pulses spaced 160 cycles apart. Then three pops return 0x55, 0x00, 0xFF, `fifo_empty`=1.
3. **False start:** a 5-cycle low glitch on `rx` → no `rx_done`, no `frame_err`, FSM back in IDLE. A following frame 0x3C is received correctly.
4. **Framing error:** frame 0x81 with stop bit 0 → one `frame_err` pulse, `count` unchanged.
5. **Overrun:** 5 frames with no reads → `fifo_full`=1 after 4, 5th byte dropped, `overrun`=1. Data reads back as bytes 1–4. `clr_err` then clears `overrun`.
6. **Full-boundary write/read:** with the FIFO full, assert `rd_en` on the stop-sample edge of a new byte → `rx_done` pulses, `count` stays 4, `overrun` stays 0, and the new byte is read last.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO drained by rd_en.
// Sticky overrun on a full FIFO; a one-cycle frame_err pulse on a bad stop bit.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 100,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic [7:0]    data_out,
  output logic          rx_done,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   count,
  output logic          frame_err,
  output logic          overrun
);

  // state | meaning
  // IDLE  | line idle, waiting for rxs low
  // START | timing to mid start bit, rejects glitches
  // DATA  | sampling 8 data bits LSB first
  // STOP  | sampling stop bit, then write / drop byte

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST_C = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          rx_meta, rxs;
  logic          wr_fire, ferr_fire, ovr_fire, rd_fire;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    wr_fire    = 1'b0;
    ferr_fire  = 1'b0;
    ovr_fire   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        if (cnt == HALF_C) begin
          cnt_nx = '0;
          if (!rxs) begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == LAST_C) begin
          cnt_nx     = '0;
          shift_nx   = {rxs, shift[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST_C) begin
          // back to IDLE on the sample edge so a start half a bit later is caught
          cnt_nx   = '0;
          state_nx = IDLE;
          if (!rxs)                     ferr_fire = 1'b1;
          else if (!fifo_full || rd_en) wr_fire   = 1'b1;
          else                          ovr_fire  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // an empty FIFO ignores the pop, so a write into it always lands
  assign rd_fire = rd_en && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done   <= wr_fire;
      frame_err <= ferr_fire;
      if (ovr_fire)     overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  // memory is not reset, so mask the head while empty
  assign data_out   = fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule
